// File: rtl/packet_assembly_buffer_pkg.sv
// Shared flit/packet types and flit decode helpers for the packet assembly buffer.
// A packet is identified by its key; MAX_FLIT_NUM bounds both packet length and slot buffer depth.
package packet_assembly_buffer_pkg;

  localparam int KEY_W        = 4;
  localparam int DATA_W       = 16;
  localparam int MAX_FLIT_NUM = 4;
  localparam int TAIL_W       = $clog2(MAX_FLIT_NUM + 1);

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_kind_e;

  typedef logic [KEY_W-1:0] packet_key_t;

  typedef struct packed {
    flit_kind_e          kind;
    packet_key_t         key;
    logic [DATA_W-1:0]   data;
  } flit_t;

  typedef struct packed {
    packet_key_t                 key;
    logic [TAIL_W-1:0]           flit_count;
    flit_t [MAX_FLIT_NUM-1:0]    flits;
  } packet_element_t;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'b00,
    SLOT_FILLING  = 2'b01,
    SLOT_COMPLETE = 2'b10
  } slot_state_e;

  function automatic logic is_head(flit_t f);
    return (f.kind == FLIT_HEAD) || (f.kind == FLIT_HEADTAIL);
  endfunction

  function automatic logic is_tail(flit_t f);
    return (f.kind == FLIT_TAIL) || (f.kind == FLIT_HEADTAIL);
  endfunction

  function automatic packet_key_t get_packet_key(flit_t f);
    return f.key;
  endfunction

endpackage

// File: rtl/completion_index_fifo.sv
// Small FIFO of slot indices, recording the order in which packets finished assembling.
// Depth equals the slot count, so it can never hold more entries than there are slots.
module completion_index_fifo #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             nocclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [IDX_W-1:0] push_index,
  input  logic             pop,
  output logic             empty,
  output logic [IDX_W-1:0] head_index
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign empty      = (count == '0);
  assign head_index = entries[rd_ptr];
  assign do_pop     = pop && !empty;

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_index;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/packet_assembly_buffer.sv
// Reassembles keyed flit streams into whole packets across SLOT_NUM slots and
// presents completed packets, in completion order, to the transfer stage.
module packet_assembly_buffer
  import packet_assembly_buffer_pkg::*;
#(
  parameter int SLOT_NUM       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DROP_CNT_W     = 8
) (
  input  logic                  nocclk,
  input  logic                  rst_n,
  input  flit_t                 received_flit,
  input  logic                  received_flit_valid,
  output logic                  received_flit_ready,
  output packet_element_t       transfered_packet,
  output logic                  transfered_packet_valid,
  input  logic                  transfered_packet_completed,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int IDX_W   = $clog2(SLOT_NUM);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int BUF_W   = $clog2(MAX_FLIT_NUM);

  slot_state_e              slot_state [SLOT_NUM];
  packet_key_t              slot_key   [SLOT_NUM];
  flit_t [MAX_FLIT_NUM-1:0] slot_buf   [SLOT_NUM];
  logic [TAIL_W-1:0]        slot_tail  [SLOT_NUM];
  logic [TIMER_W-1:0]       slot_timer [SLOT_NUM];

  logic              flit_head, flit_tail, flit_fire;
  packet_key_t       flit_key;
  logic              any_free, match_hit;
  logic [IDX_W-1:0]  free_idx, match_idx, tgt_idx, head_idx;
  logic              slot_touch, slot_overflow, slot_write, flit_drop;
  logic [TAIL_W-1:0] wr_pos;
  logic [SLOT_NUM-1:0] timeout_hit;
  logic              fifo_push, fifo_pop, fifo_empty;

  // Heads need a free slot; body/tail flits are always taken so a full buffer never deadlocks.
  always_comb begin
    flit_head = is_head(received_flit);
    flit_tail = is_tail(received_flit);
    flit_key  = get_packet_key(received_flit);
    any_free  = 1'b0;
    free_idx  = '0;
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (slot_state[i] == SLOT_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (slot_state[i] == SLOT_FILLING && slot_key[i] == flit_key) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
    received_flit_ready = !flit_head || any_free;
    flit_fire     = received_flit_valid && received_flit_ready;
    slot_touch    = flit_fire && (flit_head || match_hit);
    tgt_idx       = (flit_head && !match_hit) ? free_idx : match_idx;
    slot_overflow = slot_touch && !flit_head &&
                    (slot_tail[match_idx] == TAIL_W'(MAX_FLIT_NUM));
    slot_write    = slot_touch && !slot_overflow;
    wr_pos        = flit_head ? '0 : slot_tail[match_idx];
    fifo_push     = slot_write && flit_tail;
    flit_drop     = flit_fire && ((flit_head && match_hit) ||
                                  (!flit_head && !match_hit) || slot_overflow);
    fifo_pop      = transfered_packet_completed && !fifo_empty;
    timeout_hit   = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      timeout_hit[i] = (slot_state[i] == SLOT_FILLING) &&
                       !(slot_touch && tgt_idx == IDX_W'(i)) &&
                       (slot_timer[i] == TIMER_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_comb begin
    transfered_packet_valid = !fifo_empty;
    transfered_packet       = '0;
    if (!fifo_empty) begin
      transfered_packet.key        = slot_key[head_idx];
      transfered_packet.flit_count = slot_tail[head_idx];
      transfered_packet.flits      = slot_buf[head_idx];
    end
  end

  // A flit aimed at a slot takes priority over that slot's timeout in the same cycle.
  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        slot_state[i] <= SLOT_FREE;
        slot_key[i]   <= '0;
        slot_tail[i]  <= '0;
        slot_timer[i] <= '0;
      end
      drop_count <= '0;
    end else begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        if (slot_touch && tgt_idx == IDX_W'(i)) begin
          slot_timer[i] <= '0;
          if (slot_overflow) begin
            slot_state[i] <= SLOT_FREE;
          end else begin
            slot_buf[i][wr_pos[BUF_W-1:0]] <= received_flit;
            slot_tail[i]  <= wr_pos + 1'b1;
            slot_key[i]   <= flit_key;
            slot_state[i] <= flit_tail ? SLOT_COMPLETE : SLOT_FILLING;
          end
        end else begin
          case (slot_state[i])
            SLOT_FREE: slot_timer[i] <= '0;
            SLOT_FILLING: begin
              if (timeout_hit[i]) begin
                slot_state[i] <= SLOT_FREE;
                slot_timer[i] <= '0;
              end else begin
                slot_timer[i] <= slot_timer[i] + 1'b1;
              end
            end
            SLOT_COMPLETE: begin
              if (fifo_pop && head_idx == IDX_W'(i)) slot_state[i] <= SLOT_FREE;
            end
            default: slot_state[i] <= SLOT_FREE;
          endcase
        end
      end
      if ((flit_drop || (|timeout_hit)) && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  completion_index_fifo #(
    .DEPTH (SLOT_NUM),
    .IDX_W (IDX_W)
  ) u_completion_fifo (
    .nocclk     (nocclk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_index (tgt_idx),
    .pop        (fifo_pop),
    .empty      (fifo_empty),
    .head_index (head_idx)
  );

endmodule
